hwag_ign_ch: RTL and testbench
==============================

# hwag_ign_ch

Ignition coil channel placed directly downstream of `hwag`. It consumes the angle counter and step strobe that `hwag` produces and drives one coil output: charge starts at a programmed angle and the spark fires at a second programmed angle. A dwell-time watchdog limits charge length, and loss of angle sync forces the coil off. `hwag` instantiates one channel per coil from its SSRAM registers HWAIGNCHRGL and HWAIGNANGL.

## Interface
Parameters:
- `ANGLE_W`, 12: width of the angle bus. Angle range is 0..HWAATOP, e.g. 3839.
- `DWELL_W`, 16: width of the dwell watchdog counter and its limit.

Ports:
- `clk`, input, 1: system clock. The block uses this single clock only.
- `rst`, input, 1: reset, synchronous and active-low.
- `angle_i`, input, ANGLE_W: current angle from `hwag`. It wraps from HWAATOP to 0.
- `angle_stb_i`, input, 1: one-cycle pulse meaning `angle_i` advanced by one step this cycle.
- `sync_i`, input, 1: `hwag` angle-valid flag (tooth gap found).
- `en_i`, input, 1: channel enable.
- `chrg_ang_i`, input, ANGLE_W: charge-start angle.
- `fire_ang_i`, input, ANGLE_W: fire angle.
- `max_dwell_i`, input, DWELL_W: dwell limit in `clk` cycles. 0 disables the limit.
- `cfg_ld_i`, input, 1: strobe that latches the three config inputs into pending registers.
- `coil_o`, output, 1: coil drive, registered, high while charging.
- `chrg_ev_o`, output, 1: one-cycle pulse at charge start.
- `fire_ev_o`, output, 1: one-cycle pulse at a normal angle fire.
- `ovr_ev_o`, output, 1: one-cycle pulse when the dwell watchdog forces the coil off.
- `state_o`, output, 2: current state encoding.

## Operation
- States, with `state_o` encoding:
  - IDLE (0): waiting for enable and sync.
  - WAIT_CHRG (1): armed, waiting for the charge angle.
  - CHARGING (2): coil high.
  - OVERRUN (3): watchdog has fired; waiting for the fire angle to re-align.
- A "hit" on angle X means: `angle_stb_i` is 1 and `angle_i == X` in the same cycle.
- Transitions:
  - IDLE -> WAIT_CHRG when `en_i` and `sync_i` are both 1.
  - WAIT_CHRG -> CHARGING on a charge hit.
    - Coil goes high, `chrg_ev_o` pulses, dwell counter is cleared.
    - If charge and fire angles are equal, the hit is ignored and the state is held.
  - CHARGING -> WAIT_CHRG on a fire hit. Coil goes low, `fire_ev_o` pulses.
  - CHARGING -> OVERRUN when `max_dwell_i` ≠ 0 and the dwell counter reaches the active limit.
    - Coil goes low and `ovr_ev_o` pulses.
    - `fire_ev_o` does not pulse.
  - OVERRUN -> WAIT_CHRG on a fire hit. No event pulse.
  - Any state -> IDLE in the cycle after `sync_i` or `en_i` is 0.
    - Coil is forced low with no event pulse.
- Dwell counter:
  - Increments every `clk` cycle in CHARGING.
  - Saturates at all-ones.
  - Is cleared outside CHARGING.
- Config shadowing:
  - `cfg_ld_i` writes the pending registers.
  - Pending values become active when the block enters or sits in IDLE or WAIT_CHRG, never mid-charge.
  - An angle change therefore cannot truncate or extend a charge already in progress.
- Wrap-around needs no special handling. Equality compare on the stepped angle covers charge near HWAATOP and fire near 0.
- Simultaneous events in CHARGING:
  - Fire hit and watchdog limit in the same cycle: the fire hit wins (`fire_ev_o`, not `ovr_ev_o`).
  - Sync loss and a hit in the same cycle: sync loss wins.

## Timing
- Reset state, while `rst` is 0:
  - State is IDLE.
  - `coil_o`, all event outputs and `state_o` are 0.
  - Pending and active config registers are 0.
  - Dwell counter is 0.
- All outputs are registered. Response latency is one `clk` cycle after the qualifying input cycle:
  - Hit → `coil_o` edge and event pulse: 1 cycle.
  - Sync/enable drop → `coil_o` low: 1 cycle.
- Event outputs are high for exactly one cycle.
- Watchdog timing: `coil_o` is high for exactly `max_dwell_i` cycles before a forced off.
- A config load is usable for a hit two cycles after `cfg_ld_i`, provided the state is IDLE or WAIT_CHRG.
- Reset asserted mid-charge: `coil_o` is 0 on the next clock edge.

## Structure
- Shared package `hwag_pkg`:
  - `ign_state_t` enum: IDLE, WAIT_CHRG, CHARGING, OVERRUN.
  - Default `ANGLE_W` and `DWELL_W` constants.
  - HWAATOP reset constant.
- Sub-module `hwag_dwell_wdt`: a saturating counter with clear and a limit-match output.
- The FSM, shadow registers and hit comparators live in `hwag_ign_ch`.

## Test plan
- Normal cycle. Stimulus:
  - sync=1, en=1, chrg=1024, fire=3830, max_dwell=0.
  - Step the angle 0..3839 twice.

  Required response, each revolution:
  - `chrg_ev_o` pulses once, 1 cycle after the hit on angle 1024.
  - `fire_ev_o` pulses once, 1 cycle after the hit on angle 3830.
  - `coil_o` is high in between.
- Wrap. Stimulus: chrg=3800, fire=100.
  - Required response: coil is high across the 3839→0 wrap and falls 1 cycle after the hit on angle 100.
- Watchdog. Stimulus: chrg=1024, fire=3830, max_dwell=500, slow angle steps.
  - Required response: coil is high for exactly 500 cycles, then `ovr_ev_o` pulses.
  - No `fire_ev_o` at 3830; the state returns to WAIT_CHRG there.
  - The next revolution charges normally.
- Sync loss. Stimulus: drop `sync_i` mid-charge.
  - Required response: coil low and IDLE 1 cycle later, no event pulse.
  - After sync returns, the channel re-arms and charges at the next hit on angle 1024.
- Shadowing. Stimulus: during CHARGING, load fire=2000 via `cfg_ld_i`.
  - Required response: the current spark still occurs at 3830.
  - The next revolution fires at 2000.
- Edge cases:
  - chrg == fire: the coil never rises.
  - Reset pulse mid-charge: all outputs read 0 on the next clock edge.

Source files
------------

// File: rtl/hwag_pkg.sv
// hwag_pkg
// Shared types and constants for the hwag angle generator and its ignition
// channels.
//   ign_state_t   : ignition channel state, encoding is visible on state_o
//   HWAG_ANGLE_W  : default width of the angle bus
//   HWAG_DWELL_W  : default width of the dwell watchdog counter / limit
//   HWAATOP_RST   : reset value of the top angle (last step before wrap to 0)
package hwag_pkg;

    localparam int HWAG_ANGLE_W = 12;
    localparam int HWAG_DWELL_W = 16;

    localparam logic [HWAG_ANGLE_W-1:0] HWAATOP_RST = 12'd3839;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_CHRG = 2'd1,
        CHARGING  = 2'd2,
        OVERRUN   = 2'd3
    } ign_state_t;

endpackage

// File: rtl/hwag_dwell_wdt.sv
// hwag_dwell_wdt
// Saturating dwell counter with a limit-match flag for one ignition channel.
//   clk      : system clock
//   rst      : synchronous active-low reset
//   clr_i    : clear the counter (takes priority over inc_i)
//   inc_i    : count one clock cycle of dwell
//   limit_i  : dwell limit in clock cycles, 0 disables the match
//   hit_o    : combinational, high in the cycle whose closing edge makes the
//              count equal to the limit, so the coil owner can drop the coil
//              on that same edge
module hwag_dwell_wdt #(
    parameter int DWELL_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr_i,
    input  logic               inc_i,
    input  logic [DWELL_W-1:0] limit_i,
    output logic               hit_o
);

    logic [DWELL_W-1:0] cnt_q;
    logic [DWELL_W-1:0] cnt_d;
    logic [DWELL_W:0]   cntPlusOne;

    // Next count: clear wins, otherwise count up and stick at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != {DWELL_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Widened by one bit so the compare stays correct when the limit is all-ones.
    assign cntPlusOne = {1'b0, cnt_q} + {{DWELL_W{1'b0}}, 1'b1};
    assign hit_o      = inc_i && (limit_i != '0) && (cntPlusOne >= {1'b0, limit_i});

endmodule

// File: rtl/hwag_ign_ch.sv
// hwag_ign_ch
// One ignition coil channel driven by the hwag angle counter. The coil starts
// charging on a hit of the charge angle and fires on a hit of the fire angle;
// a dwell watchdog can force the coil off early, and loss of sync or enable
// drops the channel back to IDLE with the coil off.
//   clk, rst       : system clock, synchronous active-low reset
//   angle_i        : current angle, wraps from HWAATOP to 0
//   angle_stb_i    : angle_i stepped this cycle
//   sync_i, en_i   : angle valid flag and channel enable
//   chrg_ang_i     : charge-start angle (pending, via cfg_ld_i)
//   fire_ang_i     : fire angle (pending, via cfg_ld_i)
//   max_dwell_i    : dwell limit in clk cycles, 0 = no limit (pending)
//   cfg_ld_i       : latch the three config inputs into the pending registers
//   coil_o         : registered coil drive
//   chrg_ev_o, fire_ev_o, ovr_ev_o : one-cycle event pulses
//   state_o        : current ign_state_t encoding
module hwag_ign_ch
    import hwag_pkg::*;
#(
    parameter int ANGLE_W = HWAG_ANGLE_W,
    parameter int DWELL_W = HWAG_DWELL_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [ANGLE_W-1:0] angle_i,
    input  logic               angle_stb_i,
    input  logic               sync_i,
    input  logic               en_i,
    input  logic [ANGLE_W-1:0] chrg_ang_i,
    input  logic [ANGLE_W-1:0] fire_ang_i,
    input  logic [DWELL_W-1:0] max_dwell_i,
    input  logic               cfg_ld_i,
    output logic               coil_o,
    output logic               chrg_ev_o,
    output logic               fire_ev_o,
    output logic               ovr_ev_o,
    output logic [1:0]         state_o
);

    ign_state_t         state_q;
    logic               coil_q;
    logic               chrgEv_q;
    logic               fireEv_q;
    logic               ovrEv_q;

    logic [ANGLE_W-1:0] chrgAngPend_q;
    logic [ANGLE_W-1:0] fireAngPend_q;
    logic [DWELL_W-1:0] maxDwellPend_q;
    logic [ANGLE_W-1:0] chrgAngAct_q;
    logic [ANGLE_W-1:0] fireAngAct_q;
    logic [DWELL_W-1:0] maxDwellAct_q;

    logic               chrgHit;
    logic               fireHit;
    logic               wdtHit;
    logic               inCharge;

    // Pending config: captured whenever software strobes a load.
    always_ff @(posedge clk) begin
        if (!rst) begin
            chrgAngPend_q  <= '0;
            fireAngPend_q  <= '0;
            maxDwellPend_q <= '0;
        end else if (cfg_ld_i) begin
            chrgAngPend_q  <= chrg_ang_i;
            fireAngPend_q  <= fire_ang_i;
            maxDwellPend_q <= max_dwell_i;
        end
    end

    // Active config only follows pending while no charge is in progress, so a
    // reload can never move the spark of the current charge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            chrgAngAct_q  <= '0;
            fireAngAct_q  <= '0;
            maxDwellAct_q <= '0;
        end else if ((state_q == IDLE) || (state_q == WAIT_CHRG)) begin
            chrgAngAct_q  <= chrgAngPend_q;
            fireAngAct_q  <= fireAngPend_q;
            maxDwellAct_q <= maxDwellPend_q;
        end
    end

    // Plain equality on the stepped angle also covers charge/fire across the wrap.
    assign chrgHit  = angle_stb_i && (angle_i == chrgAngAct_q);
    assign fireHit  = angle_stb_i && (angle_i == fireAngAct_q);
    assign inCharge = (state_q == CHARGING);

    hwag_dwell_wdt #(
        .DWELL_W (DWELL_W)
    ) u_wdt (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (!inCharge),
        .inc_i   (inCharge),
        .limit_i (maxDwellAct_q),
        .hit_o   (wdtHit)
    );

    // Channel FSM with registered coil and event outputs. Sync/enable loss is
    // checked first so it overrides any hit, and a fire hit is checked before
    // the watchdog so a simultaneous limit still produces a normal spark.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            coil_q   <= 1'b0;
            chrgEv_q <= 1'b0;
            fireEv_q <= 1'b0;
            ovrEv_q  <= 1'b0;
        end else begin
            chrgEv_q <= 1'b0;
            fireEv_q <= 1'b0;
            ovrEv_q  <= 1'b0;
            if (!sync_i || !en_i) begin
                state_q <= IDLE;
                coil_q  <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        state_q <= WAIT_CHRG;
                    end
                    WAIT_CHRG: begin
                        if (chrgHit && (chrgAngAct_q != fireAngAct_q)) begin
                            state_q  <= CHARGING;
                            coil_q   <= 1'b1;
                            chrgEv_q <= 1'b1;
                        end
                    end
                    CHARGING: begin
                        if (fireHit) begin
                            state_q  <= WAIT_CHRG;
                            coil_q   <= 1'b0;
                            fireEv_q <= 1'b1;
                        end else if (wdtHit) begin
                            state_q <= OVERRUN;
                            coil_q  <= 1'b0;
                            ovrEv_q <= 1'b1;
                        end
                    end
                    OVERRUN: begin
                        if (fireHit) begin
                            state_q <= WAIT_CHRG;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        coil_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign coil_o    = coil_q;
    assign chrg_ev_o = chrgEv_q;
    assign fire_ev_o = fireEv_q;
    assign ovr_ev_o  = ovrEv_q;
    assign state_o   = state_q;

endmodule

// File: tb/tb_hwag_ign_ch.sv
// tb_hwag_ign_ch
// Directed bench for one ignition channel. The angle is stepped once per
// clock; every tick records which events appeared and which angle was applied
// in the cycle that caused them, and each scenario task compares those
// observations against hand-computed values.
module tb_hwag_ign_ch;

    logic        clk;
    logic        rst;
    logic [11:0] angle_i;
    logic        angle_stb_i;
    logic        sync_i;
    logic        en_i;
    logic [11:0] chrg_ang_i;
    logic [11:0] fire_ang_i;
    logic [15:0] max_dwell_i;
    logic        cfg_ld_i;
    logic        coil_o;
    logic        chrg_ev_o;
    logic        fire_ev_o;
    logic        ovr_ev_o;
    logic [1:0]  state_o;

    int vecCount  = 0;
    int missCount = 0;

    int nChrg, nFire, nOvr, nCoilHigh;
    int chrgAt, fireAt, firstFireAt, ovrAt;
    int curRun, coilMaxRun;

    hwag_ign_ch #(
        .ANGLE_W (12),
        .DWELL_W (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .angle_i     (angle_i),
        .angle_stb_i (angle_stb_i),
        .sync_i      (sync_i),
        .en_i        (en_i),
        .chrg_ang_i  (chrg_ang_i),
        .fire_ang_i  (fire_ang_i),
        .max_dwell_i (max_dwell_i),
        .cfg_ld_i    (cfg_ld_i),
        .coil_o      (coil_o),
        .chrg_ev_o   (chrg_ev_o),
        .fire_ev_o   (fire_ev_o),
        .ovr_ev_o    (ovr_ev_o),
        .state_o     (state_o)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Forget everything observed so far.
    task automatic clearObs();
        nChrg = 0; nFire = 0; nOvr = 0; nCoilHigh = 0;
        chrgAt = -1; fireAt = -1; firstFireAt = -1; ovrAt = -1;
        curRun = 0; coilMaxRun = 0;
    endtask

    // Drive one cycle of angle/strobe, clock it, then sample 1 ns after the edge.
    task automatic applyStimulus(input int ang, input bit stb);
        angle_i     = ang[11:0];
        angle_stb_i = stb;
        @(posedge clk);
        #1;
        if (chrg_ev_o) begin nChrg++; chrgAt = ang; end
        if (fire_ev_o) begin
            nFire++;
            fireAt = ang;
            if (nFire == 1) firstFireAt = ang;
        end
        if (ovr_ev_o) begin nOvr++; ovrAt = ang; end
        if (coil_o) begin
            nCoilHigh++;
            curRun++;
            if (curRun > coilMaxRun) coilMaxRun = curRun;
        end else begin
            curRun = 0;
        end
    endtask

    // Step the angle one position per clock, wrapping at 3839.
    task automatic runAngles(input int from, input int count);
        for (int i = 0; i < count; i++) begin
            applyStimulus((from + i) % 3840, 1'b1);
        end
    endtask

    // Config load pulse followed by one quiet cycle so the values reach the
    // active set if the channel is idle or armed.
    task automatic loadCfg(input int chrg, input int fire, input int dwell);
        chrg_ang_i  = chrg[11:0];
        fire_ang_i  = fire[11:0];
        max_dwell_i = dwell[15:0];
        cfg_ld_i    = 1'b1;
        applyStimulus(int'(angle_i), 1'b0);
        cfg_ld_i    = 1'b0;
        applyStimulus(int'(angle_i), 1'b0);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        applyStimulus(0, 1'b0);
        applyStimulus(0, 1'b0);
        vecCount++; if (coil_o !== 1'b0) begin missCount++; $display("[TB] FAIL reset_coil: got %0b expected 0", coil_o); end
        vecCount++; if (chrg_ev_o !== 1'b0) begin missCount++; $display("[TB] FAIL reset_chrg_ev: got %0b expected 0", chrg_ev_o); end
        vecCount++; if (fire_ev_o !== 1'b0) begin missCount++; $display("[TB] FAIL reset_fire_ev: got %0b expected 0", fire_ev_o); end
        vecCount++; if (ovr_ev_o !== 1'b0) begin missCount++; $display("[TB] FAIL reset_ovr_ev: got %0b expected 0", ovr_ev_o); end
        vecCount++; if (state_o !== 2'd0) begin missCount++; $display("[TB] FAIL reset_state: got %0d expected 0", state_o); end
        rst = 1'b1;
        applyStimulus(0, 1'b0);
        vecCount++; if (state_o !== 2'd0) begin missCount++; $display("[TB] FAIL idle_disabled_state: got %0d expected 0", state_o); end
    endtask

    task automatic test_normal();
        loadCfg(1024, 3830, 0);
        en_i = 1'b1; sync_i = 1'b1;
        applyStimulus(0, 1'b0);
        vecCount++; if (state_o !== 2'd1) begin missCount++; $display("[TB] FAIL normal_arm_state: got %0d expected 1", state_o); end
        for (int rev = 0; rev < 2; rev++) begin
            clearObs();
            runAngles(0, 3840);
            vecCount++; if (nChrg !== 1) begin missCount++; $display("[TB] FAIL normal_chrg_count rev%0d: got %0d expected 1", rev, nChrg); end
            vecCount++; if (chrgAt !== 1024) begin missCount++; $display("[TB] FAIL normal_chrg_angle rev%0d: got %0d expected 1024", rev, chrgAt); end
            vecCount++; if (nFire !== 1) begin missCount++; $display("[TB] FAIL normal_fire_count rev%0d: got %0d expected 1", rev, nFire); end
            vecCount++; if (fireAt !== 3830) begin missCount++; $display("[TB] FAIL normal_fire_angle rev%0d: got %0d expected 3830", rev, fireAt); end
            vecCount++; if (coilMaxRun !== 2806 || nCoilHigh !== 2806) begin missCount++; $display("[TB] FAIL normal_coil_high rev%0d: got run %0d total %0d expected 2806", rev, coilMaxRun, nCoilHigh); end
            vecCount++; if (nOvr !== 0) begin missCount++; $display("[TB] FAIL normal_no_ovr rev%0d: got %0d expected 0", rev, nOvr); end
        end
    endtask

    task automatic test_wrap();
        loadCfg(3800, 100, 0);
        clearObs();
        runAngles(0, 3840 + 200);
        vecCount++; if (nChrg !== 1 || chrgAt !== 3800) begin missCount++; $display("[TB] FAIL wrap_chrg: got count %0d angle %0d expected 1 at 3800", nChrg, chrgAt); end
        vecCount++; if (nFire !== 1 || fireAt !== 100) begin missCount++; $display("[TB] FAIL wrap_fire: got count %0d angle %0d expected 1 at 100", nFire, fireAt); end
        vecCount++; if (coilMaxRun !== 140 || nCoilHigh !== 140) begin missCount++; $display("[TB] FAIL wrap_coil_high: got run %0d total %0d expected 140", coilMaxRun, nCoilHigh); end
    endtask

    task automatic test_watchdog();
        loadCfg(1024, 3830, 500);
        clearObs();
        runAngles(0, 3830);
        vecCount++; if (state_o !== 2'd3) begin missCount++; $display("[TB] FAIL wdt_overrun_state: got %0d expected 3", state_o); end
        vecCount++; if (coilMaxRun !== 500 || nCoilHigh !== 500) begin missCount++; $display("[TB] FAIL wdt_coil_high: got run %0d total %0d expected 500", coilMaxRun, nCoilHigh); end
        vecCount++; if (nOvr !== 1 || ovrAt !== 1524) begin missCount++; $display("[TB] FAIL wdt_ovr_event: got count %0d angle %0d expected 1 at 1524", nOvr, ovrAt); end
        runAngles(3830, 1);
        vecCount++; if (state_o !== 2'd1) begin missCount++; $display("[TB] FAIL wdt_realign_state: got %0d expected 1", state_o); end
        vecCount++; if (nFire !== 0) begin missCount++; $display("[TB] FAIL wdt_no_fire: got %0d expected 0", nFire); end
        runAngles(3831, 9);
        clearObs();
        runAngles(0, 1030);
        vecCount++; if (nChrg !== 1 || chrgAt !== 1024 || coil_o !== 1'b1) begin missCount++; $display("[TB] FAIL wdt_next_rev_chrg: got count %0d angle %0d coil %0b expected 1 at 1024 coil 1", nChrg, chrgAt, coil_o); end
        runAngles(1030, 2810);
    endtask

    // Limit lands on the same cycle as the fire hit: the spark must win.
    task automatic test_back_to_back();
        loadCfg(1024, 3830, 2806);
        clearObs();
        runAngles(0, 3840);
        vecCount++; if (nFire !== 1 || fireAt !== 3830) begin missCount++; $display("[TB] FAIL tie_fire: got count %0d angle %0d expected 1 at 3830", nFire, fireAt); end
        vecCount++; if (nOvr !== 0) begin missCount++; $display("[TB] FAIL tie_no_ovr: got %0d expected 0", nOvr); end
        vecCount++; if (nCoilHigh !== 2806) begin missCount++; $display("[TB] FAIL tie_coil_high: got %0d expected 2806", nCoilHigh); end
    endtask

    task automatic test_sync_loss();
        loadCfg(1024, 3830, 0);
        runAngles(0, 1100);
        clearObs();
        sync_i = 1'b0;
        applyStimulus(1100, 1'b1);
        vecCount++; if (coil_o !== 1'b0 || state_o !== 2'd0) begin missCount++; $display("[TB] FAIL sync_loss_drop: got coil %0b state %0d expected coil 0 state 0", coil_o, state_o); end
        vecCount++; if (nChrg + nFire + nOvr !== 0) begin missCount++; $display("[TB] FAIL sync_loss_no_event: got %0d events expected 0", nChrg + nFire + nOvr); end
        sync_i = 1'b1;
        applyStimulus(1100, 1'b0);
        vecCount++; if (state_o !== 2'd1) begin missCount++; $display("[TB] FAIL sync_rearm_state: got %0d expected 1", state_o); end
        clearObs();
        runAngles(1101, 2739 + 1030);
        vecCount++; if (nChrg !== 1 || chrgAt !== 1024 || nFire !== 0 || coil_o !== 1'b1) begin missCount++; $display("[TB] FAIL sync_recharge: got chrg %0d at %0d fire %0d coil %0b expected 1 at 1024 fire 0 coil 1", nChrg, chrgAt, nFire, coil_o); end
    endtask

    // Enters charging (from the previous task), reloads fire=2000 mid-charge.
    task automatic test_shadow();
        loadCfg(1024, 2000, 0);
        clearObs();
        runAngles(1030, 2810 + 3840);
        vecCount++; if (firstFireAt !== 3830) begin missCount++; $display("[TB] FAIL shadow_current_fire: got %0d expected 3830", firstFireAt); end
        vecCount++; if (nFire !== 2 || fireAt !== 2000) begin missCount++; $display("[TB] FAIL shadow_next_fire: got count %0d angle %0d expected 2 at 2000", nFire, fireAt); end
        vecCount++; if (nChrg !== 1 || chrgAt !== 1024) begin missCount++; $display("[TB] FAIL shadow_chrg: got count %0d angle %0d expected 1 at 1024", nChrg, chrgAt); end
    endtask

    task automatic test_edges();
        loadCfg(500, 500, 0);
        clearObs();
        runAngles(0, 3840);
        vecCount++; if (nChrg !== 0 || nCoilHigh !== 0) begin missCount++; $display("[TB] FAIL equal_angles_no_charge: got chrg %0d coil cycles %0d expected 0 0", nChrg, nCoilHigh); end
        vecCount++; if (state_o !== 2'd1) begin missCount++; $display("[TB] FAIL equal_angles_state: got %0d expected 1", state_o); end
        loadCfg(1024, 3830, 0);
        runAngles(0, 1100);
        vecCount++; if (coil_o !== 1'b1) begin missCount++; $display("[TB] FAIL pre_reset_coil: got %0b expected 1", coil_o); end
        rst = 1'b0;
        applyStimulus(1100, 1'b1);
        vecCount++; if ({coil_o, chrg_ev_o, fire_ev_o, ovr_ev_o, state_o} !== 6'd0) begin missCount++; $display("[TB] FAIL reset_mid_charge: got coil %0b ev %0b%0b%0b state %0d expected all 0", coil_o, chrg_ev_o, fire_ev_o, ovr_ev_o, state_o); end
        rst = 1'b1;
        applyStimulus(1101, 1'b0);
    endtask

    initial begin
        rst = 1'b0; angle_i = '0; angle_stb_i = 1'b0; sync_i = 1'b0; en_i = 1'b0;
        chrg_ang_i = '0; fire_ang_i = '0; max_dwell_i = '0; cfg_ld_i = 1'b0;
        clearObs();
        test_reset();
        test_normal();
        test_wrap();
        test_watchdog();
        test_back_to_back();
        test_sync_loss();
        test_shadow();
        test_edges();
        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
